// File: rtl/exu_cal_mc_pkg.sv
// Shared opcode bit indices, state encoding and opcode sanity helper for the
// multi-cycle execute calculation unit.
package exu_cal_mc_pkg;

  localparam int CIRNO_CALMC_OP_NUM = 10;

  localparam int CIRNO_CALMC_ADD  = 0;
  localparam int CIRNO_CALMC_SUB  = 1;
  localparam int CIRNO_CALMC_SLL  = 2;
  localparam int CIRNO_CALMC_SRL  = 3;
  localparam int CIRNO_CALMC_SRA  = 4;
  localparam int CIRNO_CALMC_XOR  = 5;
  localparam int CIRNO_CALMC_OR   = 6;
  localparam int CIRNO_CALMC_AND  = 7;
  localparam int CIRNO_CALMC_SLT  = 8;
  localparam int CIRNO_CALMC_SLTU = 9;

  typedef enum logic [1:0] {
    CIRNO_CALMC_S_IDLE  = 2'd0,
    CIRNO_CALMC_S_SHIFT = 2'd1,
    CIRNO_CALMC_S_DONE  = 2'd2
  } cal_state_e;

  function automatic logic is_onehot(input logic [CIRNO_CALMC_OP_NUM-1:0] op);
    return (op != '0) &&
           ((op & (op - {{(CIRNO_CALMC_OP_NUM-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/exu_cal_mc_shstep.sv
// Combinational single-step shifter: moves the working value by i_amt bits,
// left, logical right, or arithmetic right.
module exu_cal_mc_shstep #(
  parameter int XLEN  = 32,
  parameter int AMT_W = 6
) (
  input  logic [XLEN-1:0]  i_val,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_left,
  input  logic             i_arith,
  output logic [XLEN-1:0]  o_val
);

  always_comb begin
    if (i_left)       o_val = i_val << i_amt;
    else if (i_arith) o_val = $unsigned($signed(i_val) >>> i_amt);
    else              o_val = i_val >> i_amt;
  end

endmodule

// File: rtl/exu_cal_mc.sv
// Multi-cycle integer calculation unit: single-cycle ALU ops, iterative
// shifter limited to SH_STEP bits per cycle, registered result to writeback.
module exu_cal_mc
  import exu_cal_mc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SH_STEP = 4,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic                          hs_ex4cal_val,
  output logic                          hs_cal4ex_rdy,
  input  logic [CIRNO_CALMC_OP_NUM-1:0] i_op,
  input  logic [XLEN-1:0]               i_opn1,
  input  logic [XLEN-1:0]               i_opn2,
  output logic                          hs_cal4wb_val,
  input  logic                          hs_wb4cal_rdy,
  output logic [XLEN-1:0]               o_res,
  output logic                          o_err
);

  // One extra bit so SH_STEP == XLEN still fits in the step amount.
  localparam int AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(SH_STEP);

  cal_state_e          state_q, state_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                err_q, err_d;
  logic [XLEN-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]  rem_q, rem_d;
  logic                left_q, left_d;
  logic                arith_q, arith_d;

  logic                accept;
  logic                is_shift;
  logic [SHAMT_W-1:0]  shamt;
  logic [AMT_W-1:0]    step;
  logic [SHAMT_W-1:0]  rem_nxt;
  logic [XLEN-1:0]     step_out;
  logic [XLEN-1:0]     alu_res;
  logic [XLEN:0]       diff;

  assign hs_cal4ex_rdy = !rst && !i_flush &&
                         ((state_q == CIRNO_CALMC_S_IDLE) ||
                          ((state_q == CIRNO_CALMC_S_DONE) && hs_wb4cal_rdy));
  assign accept        = hs_ex4cal_val && hs_cal4ex_rdy;
  assign hs_cal4wb_val = (state_q == CIRNO_CALMC_S_DONE);
  assign o_res         = res_q;
  assign o_err         = err_q;

  assign is_shift = i_op[CIRNO_CALMC_SLL] | i_op[CIRNO_CALMC_SRL] | i_op[CIRNO_CALMC_SRA];
  assign shamt    = i_opn2[SHAMT_W-1:0];
  assign step     = ({1'b0, rem_q} < STEP_MAX) ? {1'b0, rem_q} : STEP_MAX;
  assign rem_nxt  = rem_q - step[SHAMT_W-1:0];

  exu_cal_mc_shstep #(.XLEN(XLEN), .AMT_W(AMT_W)) u_shstep (
    .i_val   (work_q),
    .i_amt   (step),
    .i_left  (left_q),
    .i_arith (arith_q),
    .o_val   (step_out)
  );

  // SUB, SLT and SLTU share one XLEN+1 subtract; its top bit is the unsigned borrow.
  always_comb begin
    diff    = {1'b0, i_opn1} - {1'b0, i_opn2};
    alu_res = '0;
    if (i_op[CIRNO_CALMC_ADD])  alu_res = i_opn1 + i_opn2;
    if (i_op[CIRNO_CALMC_SUB])  alu_res = diff[XLEN-1:0];
    if (i_op[CIRNO_CALMC_XOR])  alu_res = i_opn1 ^ i_opn2;
    if (i_op[CIRNO_CALMC_OR])   alu_res = i_opn1 | i_opn2;
    if (i_op[CIRNO_CALMC_AND])  alu_res = i_opn1 & i_opn2;
    if (i_op[CIRNO_CALMC_SLT])  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_opn1) < $signed(i_opn2))};
    if (i_op[CIRNO_CALMC_SLTU]) alu_res = {{(XLEN-1){1'b0}}, diff[XLEN]};
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = err_q;
    work_d  = work_q;
    rem_d   = rem_q;
    left_d  = left_q;
    arith_d = arith_q;

    case (state_q)
      CIRNO_CALMC_S_SHIFT: begin
        work_d = step_out;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) begin
          state_d = CIRNO_CALMC_S_DONE;
          res_d   = step_out;
          err_d   = 1'b0;
        end
      end
      CIRNO_CALMC_S_DONE: if (hs_wb4cal_rdy) state_d = CIRNO_CALMC_S_IDLE;
      default: ;
    endcase

    // Accept covers both IDLE and the DONE->DONE back-to-back reload.
    if (accept) begin
      left_d  = i_op[CIRNO_CALMC_SLL];
      arith_d = i_op[CIRNO_CALMC_SRA];
      err_d   = 1'b0;
      if (!is_onehot(i_op)) begin
        state_d = CIRNO_CALMC_S_DONE;
        res_d   = '0;
        err_d   = 1'b1;
      end else if (is_shift) begin
        work_d = i_opn1;
        rem_d  = shamt;
        if (shamt == '0) begin
          state_d = CIRNO_CALMC_S_DONE;
          res_d   = i_opn1;
        end else begin
          state_d = CIRNO_CALMC_S_SHIFT;
        end
      end else begin
        state_d = CIRNO_CALMC_S_DONE;
        res_d   = alu_res;
      end
    end

    if (i_flush) begin
      state_d = CIRNO_CALMC_S_IDLE;
      res_d   = '0;
      err_d   = 1'b0;
      work_d  = '0;
      rem_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CIRNO_CALMC_S_IDLE;
      res_q   <= '0;
      err_q   <= 1'b0;
      work_q  <= '0;
      rem_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule
